// File: rtl/clint_pkg.sv
// ---------------------------------------------------------------------------
// clint_pkg
// Shared definitions for the CLINT register-port arbiter slice.
//   - Register window base offsets (MSIP, MTIMECMP, MTIME).
//   - Request/response record types for one register access.
//   - addr_legal(): address/permission decode used by the arbiter top.
// ---------------------------------------------------------------------------
package clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [63:0] wdata;
  } clint_reg_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } clint_reg_rsp_t;

  // An access is legal when it hits an aligned MSIP word, an aligned
  // MTIMECMP doubleword, or MTIME itself. Writing MTIME additionally needs
  // the requester's write permission; reading it is always allowed.
  // Window checks use offset-from-base so an unsigned subtraction that
  // underflows lands far outside the window and simply fails the compare.
  function automatic logic addr_legal(input logic [15:0] addr,
                                      input logic        we,
                                      input logic        wr_allowed,
                                      input int unsigned nr_cores);
    int unsigned a;
    logic        ok;
    a  = 32'(addr);
    ok = 1'b0;
    if (((a - 32'(MSIP_BASE)) < (32'd4 * nr_cores)) && (addr[1:0] == 2'b00)) begin
      ok = 1'b1;
    end else if ((a >= 32'(MTIMECMP_BASE)) &&
                 ((a - 32'(MTIMECMP_BASE)) < (32'd8 * nr_cores)) &&
                 (addr[2:0] == 3'b000)) begin
      ok = 1'b1;
    end else if (addr == MTIME_BASE) begin
      ok = !we || wr_allowed;
    end
    return ok;
  endfunction

endpackage

// File: rtl/clint_rr_arb.sv
// ---------------------------------------------------------------------------
// clint_rr_arb
// Round-robin arbiter owning the rotating priority pointer.
//   clk_i   in   clock
//   rst_ni  in   asynchronous reset, active low (pointer -> 0)
//   req_i   in   [N]     request vector
//   gnt_o   out  [N]     one-hot grant, combinational from req_i and pointer
//   idx_o   out  [IDXW]  index of the granted port (0 when nothing granted)
// The winner is the first requester at or after the pointer, wrapping.
// After a grant the pointer moves to the slot just past the winner; it
// holds when nothing is granted. With N==1 the pointer stays at 0 and the
// grant is simply the request.
// ---------------------------------------------------------------------------
module clint_rr_arb #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] idx_o
);

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam logic [IDXW-1:0] ONE  = IDXW'(1);

  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] w_idx;
  logic            w_any;
  logic [N-1:0]    w_gnt;

  // Two descending passes: the first finds the lowest requester below the
  // pointer (wrap-around candidates), the second overrides it with the
  // lowest requester at or above the pointer, which has higher priority.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k] && (IDXW'(k) < r_ptr)) begin
        w_idx = IDXW'(k);
        w_any = 1'b1;
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k] && (IDXW'(k) >= r_ptr)) begin
        w_idx = IDXW'(k);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    for (int k = 0; k < N; k++) begin
      w_gnt[k] = w_any && (w_idx == IDXW'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_idx == LAST) ? '0 : w_idx + ONE;
    end
  end

  assign gnt_o = w_gnt;
  assign idx_o = w_idx;

endmodule

// File: rtl/clint_reg_arbiter.sv
// ---------------------------------------------------------------------------
// clint_reg_arbiter
// Shares the single CLINT register port between NR_PORTS requesters.
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_i/addr_i/we_i/wdata_i  per-port request bus (held until granted)
//   gnt_o                   one-hot grant in the accept cycle
//   rvalid_o/rdata_o/err_o  per-port response, one cycle after the grant
//   en_o/we_o/addr_o/wdata_o  CLINT register port, driven in the grant cycle
//   rdata_i                 CLINT read data, combinational from en_o/addr_o
// Illegal accesses still win their round-robin slot but never enable the
// CLINT port; they are answered locally with err=1 and rdata=0.
// ---------------------------------------------------------------------------
module clint_reg_arbiter
  import clint_pkg::*;
#(
  parameter int unsigned         NR_PORTS      = 2,
  parameter int unsigned         NR_CORES      = 1,
  parameter logic [NR_PORTS-1:0] MTIME_WR_MASK = '1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NR_PORTS-1:0]       req_i,
  input  logic [NR_PORTS-1:0][15:0] addr_i,
  input  logic [NR_PORTS-1:0]       we_i,
  input  logic [NR_PORTS-1:0][63:0] wdata_i,
  output logic [NR_PORTS-1:0]       gnt_o,
  output logic [NR_PORTS-1:0]       rvalid_o,
  output logic [NR_PORTS-1:0][63:0] rdata_o,
  output logic [NR_PORTS-1:0]       err_o,
  output logic                      en_o,
  output logic                      we_o,
  output logic [15:0]               addr_o,
  output logic [63:0]               wdata_o,
  input  logic [63:0]               rdata_i
);

  localparam int unsigned IDXW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  logic [NR_PORTS-1:0]                 w_gnt;
  logic [IDXW-1:0]                     w_idx;
  logic                                w_any;
  clint_reg_req_t                      w_req;
  logic                                w_legal;
  logic                                w_en;
  logic [NR_PORTS-1:0]                 r_rvalid;
  clint_reg_rsp_t [NR_PORTS-1:0]       r_rsp;

  clint_rr_arb #(.N(NR_PORTS)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .gnt_o  (w_gnt),
    .idx_o  (w_idx)
  );

  assign w_any = |w_gnt;

  always_comb begin
    w_req.addr  = addr_i[w_idx];
    w_req.we    = we_i[w_idx];
    w_req.wdata = wdata_i[w_idx];
  end

  assign w_legal = addr_legal(w_req.addr, w_req.we, MTIME_WR_MASK[w_idx], NR_CORES);
  assign w_en    = w_any && w_legal;

  // The CLINT side is fully zeroed on illegal or idle cycles so a rejected
  // access leaves no trace on the shared port.
  assign gnt_o   = w_gnt;
  assign en_o    = w_en;
  assign we_o    = w_en && w_req.we;
  assign addr_o  = w_en ? w_req.addr  : '0;
  assign wdata_o = w_en ? w_req.wdata : '0;

  // Response stage: only the port granted last cycle sees anything; read
  // data is captured from the CLINT in the grant cycle itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= '0;
      r_rsp    <= '0;
    end else begin
      r_rvalid <= w_gnt;
      for (int k = 0; k < NR_PORTS; k++) begin
        r_rsp[k].err   <= w_gnt[k] && !w_legal;
        r_rsp[k].rdata <= (w_gnt[k] && w_legal && !w_req.we) ? rdata_i : '0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NR_PORTS; k++) begin
      rdata_o[k] = r_rsp[k].rdata;
      err_o[k]   = r_rsp[k].err;
    end
  end

  assign rvalid_o = r_rvalid;

endmodule

// File: tb/tb_clint_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_clint_reg_arbiter
// Self-checking bench: four requesters, two cores, MTIME writable only by
// ports 1 and 3. A behavioural model predicts grants, CLINT port activity
// and responses each cycle; directed scenarios come first, then random.
// ---------------------------------------------------------------------------
module tb_clint_reg_arbiter;

  localparam int NP = 4;
  localparam int NC = 2;
  localparam logic [NP-1:0] WMASK = 4'b1010;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [NP-1:0]       req_i = '0;
  logic [NP-1:0][15:0] addr_i = '0;
  logic [NP-1:0]       we_i = '0;
  logic [NP-1:0][63:0] wdata_i = '0;
  logic [NP-1:0]       gnt_o;
  logic [NP-1:0]       rvalid_o;
  logic [NP-1:0][63:0] rdata_o;
  logic [NP-1:0]       err_o;
  logic                en_o;
  logic                we_o;
  logic [15:0]         addr_o;
  logic [63:0]         wdata_o;
  logic [63:0]         rdata_i;
  logic [31:0]         salt = '0;

  int nCompared = 0;
  int nMismatched = 0;

  // Next-cycle stimulus, filled in by the scenarios before applyStimulus.
  logic [NP-1:0] nReq = '0;
  logic [NP-1:0] nWe = '0;
  logic [15:0]   nAddr [NP];
  logic [63:0]   nWdata [NP];

  // Model state: rotating priority, expected response, waiting times.
  int            mPtr = 0;
  int            lastWinner = -1;
  logic [NP-1:0] eRvalid = '0;
  logic [NP-1:0] eErr = '0;
  logic [63:0]   eRdata [NP];
  int            waitCnt [NP];

  // Free-running clock, 10 time-unit period.
  always #5 clk_i = ~clk_i;

  // CLINT stand-in: read data depends on address and a per-cycle salt so a
  // response can be tied to its own grant cycle; garbage when disabled.
  assign rdata_i = en_o ? {salt, 16'h0000, addr_o} : 64'hFFFF_FFFF_FFFF_FFFF;

  clint_reg_arbiter #(
    .NR_PORTS      (NP),
    .NR_CORES      (NC),
    .MTIME_WR_MASK (WMASK)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .en_o     (en_o),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .rdata_i  (rdata_i)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Register map legality written straight from the decode rules.
  function automatic bit modelLegal(input int port, input logic [15:0] a, input logic w);
    int ai;
    ai = int'(a);
    if ((ai % 4 == 0) && (ai < 4 * NC)) return 1'b1;
    if ((ai >= 'h4000) && (ai < 'h4000 + 8 * NC) && (ai % 8 == 0)) return 1'b1;
    if (ai == 'hBFF8) return (!w) || (WMASK[port] == 1'b1);
    return 1'b0;
  endfunction

  function automatic logic [15:0] pickAddr();
    logic [15:0] a;
    case ($urandom_range(0, 9))
      0: a = 16'h0000;
      1: a = 16'h0004;
      2: a = 16'h0008;
      3: a = 16'h0002;
      4: a = 16'h4000;
      5: a = 16'h4008;
      6: a = 16'h4004;
      7: a = 16'h4010;
      8: a = 16'hBFF8;
      default: a = 16'($urandom);
    endcase
    return a;
  endfunction

  task automatic clearModel();
    mPtr = 0;
    lastWinner = -1;
    eRvalid = '0;
    eErr = '0;
    for (int k = 0; k < NP; k++) begin
      eRdata[k] = '0;
      waitCnt[k] = 0;
    end
  endtask

  // One cycle: check last cycle's response, drive the new request, then
  // check grant and CLINT port against the model and predict the response.
  task automatic applyStimulus();
    int            winner;
    bit            legal;
    logic [NP-1:0] expG;
    logic [15:0]   wa;
    logic          ww;
    logic [63:0]   wd;
    @(posedge clk_i);
    #1;
    checkOutput("rvalid", 64'(rvalid_o), 64'(eRvalid));
    checkOutput("err", 64'(err_o), 64'(eErr));
    for (int k = 0; k < NP; k++) begin
      checkOutput($sformatf("rdata%0d", k), rdata_o[k], eRdata[k]);
    end
    salt = $urandom;
    req_i = nReq;
    we_i = nWe;
    for (int k = 0; k < NP; k++) begin
      addr_i[k] = nAddr[k];
      wdata_i[k] = nWdata[k];
    end
    #1;
    winner = -1;
    for (int i = 0; i < NP; i++) begin
      int c;
      c = (mPtr + i) % NP;
      if (winner < 0 && nReq[c]) winner = c;
    end
    expG = '0;
    legal = 1'b0;
    wa = '0;
    ww = 1'b0;
    wd = '0;
    if (winner >= 0) begin
      expG[winner] = 1'b1;
      legal = modelLegal(winner, nAddr[winner], nWe[winner]);
      wa = nAddr[winner];
      ww = nWe[winner];
      wd = nWdata[winner];
    end
    checkOutput("gnt", 64'(gnt_o), 64'(expG));
    checkOutput("en", 64'(en_o), 64'(legal));
    checkOutput("we", 64'(we_o), 64'(legal && ww));
    checkOutput("addr", 64'(addr_o), legal ? 64'(wa) : 64'h0);
    checkOutput("wdata", wdata_o, legal ? wd : 64'h0);
    for (int k = 0; k < NP; k++) begin
      if (nReq[k]) begin
        waitCnt[k]++;
        if (winner == k) begin
          checkOutput($sformatf("fairWait%0d", k), 64'(waitCnt[k] <= NP), 64'h1);
          waitCnt[k] = 0;
        end
      end else begin
        waitCnt[k] = 0;
      end
    end
    eRvalid = expG;
    eErr = legal ? '0 : expG;
    for (int k = 0; k < NP; k++) eRdata[k] = '0;
    if (winner >= 0 && legal && !ww) eRdata[winner] = {salt, 16'h0000, wa};
    if (winner >= 0) mPtr = (winner + 1) % NP;
    lastWinner = winner;
  endtask

  task automatic setSingle(input int port, input logic [15:0] a, input logic w, input logic [63:0] d);
    nReq = '0;
    nReq[port] = 1'b1;
    nWe = '0;
    nWe[port] = w;
    nAddr[port] = a;
    nWdata[port] = d;
  endtask

  // Reset asserted right after a grant, before its response registers.
  task automatic applyReset();
    rst_ni = 1'b0;
    nReq = '0;
    req_i = '0;
    clearModel();
    #1;
    checkOutput("rstRvalid", 64'(rvalid_o), 64'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Main scenario sequence.
  initial begin
    for (int k = 0; k < NP; k++) begin
      nAddr[k] = '0;
      nWdata[k] = '0;
    end
    clearModel();
    #2;
    checkOutput("rst_gnt", 64'(gnt_o), 64'h0);
    checkOutput("rst_rvalid", 64'(rvalid_o), 64'h0);
    checkOutput("rst_err", 64'(err_o), 64'h0);
    checkOutput("rst_rdata0", rdata_o[0], 64'h0);
    checkOutput("rst_en", 64'(en_o), 64'h0);
    checkOutput("rst_we", 64'(we_o), 64'h0);
    checkOutput("rst_addr", 64'(addr_o), 64'h0);
    checkOutput("rst_wdata", wdata_o, 64'h0);
    #10;
    rst_ni = 1'b1;

    $display("[TB] idle cycles");
    nReq = '0;
    repeat (5) applyStimulus();

    $display("[TB] ports 0 and 1 reading MTIME");
    nReq = 4'b0011;
    nWe = '0;
    nAddr[0] = 16'hBFF8;
    nAddr[1] = 16'hBFF8;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("altSeq", 64'(lastWinner), 64'(i % 2));
    end
    nReq = '0;
    applyStimulus();

    $display("[TB] port 1 writes MTIMECMP[1]");
    setSingle(1, 16'h4008, 1'b1, 64'hDEAD_BEEF_0000_0001);
    applyStimulus();
    checkOutput("wrEn", 64'(en_o), 64'h1);
    checkOutput("wrWe", 64'(we_o), 64'h1);
    checkOutput("wrAddr", 64'(addr_o), 64'h4008);
    checkOutput("wrData", wdata_o, 64'hDEAD_BEEF_0000_0001);
    nReq = '0;
    applyStimulus();
    checkOutput("wrRvalid", 64'(rvalid_o[1]), 64'h1);
    checkOutput("wrErr", 64'(err_o[1]), 64'h0);
    checkOutput("wrRdata", rdata_o[1], 64'h0);

    $display("[TB] illegal accesses");
    setSingle(0, 16'h4004, 1'b0, 64'h0);
    applyStimulus();
    checkOutput("illMisEn", 64'(en_o), 64'h0);
    setSingle(0, 16'h0008, 1'b0, 64'h0);
    applyStimulus();
    checkOutput("illMisErr", 64'(err_o[0]), 64'h1);
    checkOutput("illWinEn", 64'(en_o), 64'h0);
    setSingle(0, 16'hBFF8, 1'b1, 64'h1234);
    applyStimulus();
    checkOutput("illWinErr", 64'(err_o[0]), 64'h1);
    checkOutput("illMtimeEn", 64'(en_o), 64'h0);
    setSingle(1, 16'hBFF8, 1'b1, 64'h5678);
    applyStimulus();
    checkOutput("illMtimeErr", 64'(err_o[0]), 64'h1);
    checkOutput("okMtimeEn", 64'(en_o), 64'h1);
    nReq = '0;
    applyStimulus();
    checkOutput("okMtimeErr", 64'(err_o[1]), 64'h0);

    $display("[TB] reset between grant and response");
    setSingle(0, 16'h0000, 1'b0, 64'h0);
    applyStimulus();
    setSingle(1, 16'h0004, 1'b0, 64'h0);
    applyStimulus();
    checkOutput("preRstGnt", 64'(gnt_o), 64'h2);
    applyReset();
    nReq = '0;
    repeat (2) applyStimulus();
    nReq = 4'b0011;
    nWe = '0;
    nAddr[0] = 16'h4000;
    nAddr[1] = 16'h4008;
    applyStimulus();
    checkOutput("rstPtr", 64'(gnt_o), 64'h1);
    nReq = '0;
    applyStimulus();

    $display("[TB] random traffic");
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < NP; k++) begin
        if (!(nReq[k] && lastWinner != k)) begin
          nReq[k] = ($urandom_range(0, 99) < 60);
          nWe[k] = 1'($urandom_range(0, 1));
          nAddr[k] = pickAddr();
          nWdata[k] = {$urandom, $urandom};
        end
      end
      applyStimulus();
    end
    nReq = '0;
    repeat (2) applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
